// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: default divider widths, reset ratios and the
// divider FSM state encoding used by the counter stage and Select_Logic users.
package fmdll_pkg;

  localparam int         NW_DEF    = 4;
  localparam int         MW_DEF    = 2;
  localparam logic [3:0] N_RST_DEF = 4'd7;
  localparam logic [1:0] M_RST_DEF = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fmdll_mod_counter.sv
// Generic modulo counter: counts 0..i_limit, then returns to 0; o_at_limit
// flags the wrap cycle so instances can be chained.
module fmdll_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_at_limit
);

  logic [W-1:0] r_count;

  assign o_at_limit = (r_count == i_limit);
  assign o_count    = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_at_limit ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/fmdll_div_counter.sv
// FMDLL divider stage: N-period / M-frame counters, DIV strobes, and a shadow
// register that swaps in new ratios only at frame boundaries or while idle.
module fmdll_div_counter
  import fmdll_pkg::*;
#(
  parameter int            NW    = NW_DEF,
  parameter int            MW    = MW_DEF,
  parameter logic [NW-1:0] N_RST = N_RST_DEF,
  parameter logic [MW-1:0] M_RST = M_RST_DEF
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_load,
  input  logic [NW-1:0] N_in,
  input  logic [MW-1:0] M_in,
  output logic          cfg_ack,
  output logic [NW-1:0] N,
  output logic [MW-1:0] M,
  output logic [NW-1:0] N_counter,
  output logic [MW-1:0] M_counter,
  output logic          DIV_N,
  output logic          DIV_M,
  output logic          running
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [NW-1:0] r_n;
  logic [MW-1:0] r_m;
  logic [NW-1:0] r_pend_n;
  logic [MW-1:0] r_pend_m;
  logic          r_pend;
  logic          r_div_n;
  logic          r_div_m;
  logic          r_cfg_ack;

  logic w_count;
  logic w_n_at;
  logic w_m_at;
  logic w_frame;
  logic w_apply;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for the next-state signal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en)  w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counting only while RUN persists; leaving RUN clears on the same edge.
  assign w_count = (r_state == RUN) && en;

  fmdll_mod_counter #(.W(NW)) u_n_cnt (
    .clk        (clk_out),
    .rst_n      (rst_n),
    .i_clr      (!w_count),
    .i_en       (w_count),
    .i_limit    (r_n),
    .o_count    (N_counter),
    .o_at_limit (w_n_at)
  );

  fmdll_mod_counter #(.W(MW)) u_m_cnt (
    .clk        (clk_out),
    .rst_n      (rst_n),
    .i_clr      (!w_count),
    .i_en       (w_count && w_n_at),
    .i_limit    (r_m),
    .o_count    (M_counter),
    .o_at_limit (w_m_at)
  );

  // A fresh cfg_load at an apply point bypasses the shadow registers.
  assign w_frame = w_n_at && w_m_at;
  assign w_apply = ((r_state == IDLE) || w_frame) && (cfg_load || r_pend);

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= N_RST;
      r_m       <= M_RST;
      r_pend_n  <= '0;
      r_pend_m  <= '0;
      r_pend    <= 1'b0;
      r_div_n   <= 1'b0;
      r_div_m   <= 1'b0;
      r_cfg_ack <= 1'b0;
    end else begin
      r_div_n   <= w_count && w_n_at;
      r_div_m   <= w_count && w_frame;
      r_cfg_ack <= w_apply;
      if (cfg_load) begin
        r_pend_n <= N_in;
        r_pend_m <= M_in;
      end
      if (w_apply) begin
        r_pend <= 1'b0;
        r_n    <= cfg_load ? N_in : r_pend_n;
        r_m    <= cfg_load ? M_in : r_pend_m;
      end else if (cfg_load) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign N       = r_n;
  assign M       = r_m;
  assign DIV_N   = r_div_n;
  assign DIV_M   = r_div_m;
  assign cfg_ack = r_cfg_ack;
  assign running = (r_state == RUN);

endmodule

// File: tb/tb_fmdll_div_counter.sv
// Directed bench for fmdll_div_counter: a vector table for idle/degenerate
// ratios plus hand-written sequences for frame-boundary reconfiguration.
module tb_fmdll_div_counter;

  logic       clk_out  = 1'b0;
  logic       rst_n    = 1'b1;
  logic       en       = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] N_in     = '0;
  logic [1:0] M_in     = '0;
  logic       cfg_ack;
  logic [3:0] N;
  logic [1:0] M;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N;
  logic       DIV_M;
  logic       running;

  fmdll_div_counter dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_load  (cfg_load),
    .N_in      (N_in),
    .M_in      (M_in),
    .cfg_ack   (cfg_ack),
    .N         (N),
    .M         (M),
    .N_counter (N_counter),
    .M_counter (M_counter),
    .DIV_N     (DIV_N),
    .DIV_M     (DIV_M),
    .running   (running)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    int en; int ld; int nin; int min;
    int n;  int m;  int nc;  int mc;
    int dn; int dm; int ack; int run;
  } vec_t;

  vec_t vecs[10];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int n, input int m,
                           input int nc, input int mc, input int dn,
                           input int dm, input int ack, input int run);
    check($sformatf("%s N", tag),         int'(N),         n);
    check($sformatf("%s M", tag),         int'(M),         m);
    check($sformatf("%s N_counter", tag), int'(N_counter), nc);
    check($sformatf("%s M_counter", tag), int'(M_counter), mc);
    check($sformatf("%s DIV_N", tag),     int'(DIV_N),     dn);
    check($sformatf("%s DIV_M", tag),     int'(DIV_M),     dm);
    check($sformatf("%s cfg_ack", tag),   int'(cfg_ack),   ack);
    check($sformatf("%s running", tag),   int'(running),   run);
  endtask

  // Drive inputs for one rising edge, then sample just after it.
  task automatic step(input int e, input int ld, input int ni, input int mi);
    en       = e[0];
    cfg_load = ld[0];
    N_in     = ni[3:0];
    M_in     = mi[1:0];
    @(posedge clk_out);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en ld ni mi | N  M  nc mc dn dm ack run
    vecs[0] = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1};
    vecs[3] = '{1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1};
    vecs[4] = '{1, 1, 1, 0,  1, 0, 0, 0, 1, 1, 1, 1};
    vecs[5] = '{1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1};
    vecs[6] = '{1, 0, 0, 0,  1, 0, 0, 0, 1, 1, 0, 1};
    vecs[7] = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{0, 1, 7, 3,  7, 3, 0, 0, 0, 0, 1, 0};
    vecs[9] = '{0, 0, 0, 0,  7, 3, 0, 0, 0, 0, 0, 0};

    #1 rst_n = 1'b0;
    #1 check_all("reset", 7, 3, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_out);
    #1 rst_n = 1'b1;

    // Idle config, N=0/M=0 degenerate run, reconfig every boundary, back to 7/3.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].nin, vecs[i].min);
      check_all($sformatf("vec%0d", i), vecs[i].n, vecs[i].m, vecs[i].nc,
                vecs[i].mc, vecs[i].dn, vecs[i].dm, vecs[i].ack, vecs[i].run);
    end

    // t counts edges since en rose; t=1 is the IDLE->RUN edge.
    for (int t = 1; t <= 40; t++) begin
      step(1, 0, 0, 0);
      check_all($sformatf("run7x3 t%0d", t), 7, 3, (t - 1) % 8, ((t - 1) / 8) % 4,
                int'(t > 1 && (t - 1) % 8 == 0), int'(t > 1 && (t - 1) % 32 == 0), 0, 1);
    end

    // Mid-frame load 3/1: held until the boundary edge at t=65, next frame 8 cycles.
    for (int t = 41; t <= 73; t++) begin
      int nc, mc, dn;
      step(1, int'(t == 41), 3, 1);
      if (t < 65) begin
        nc = (t - 1) % 8;  mc = ((t - 1) / 8) % 4;  dn = int'(nc == 0);
      end else begin
        nc = (t - 65) % 4; mc = ((t - 65) / 4) % 2; dn = int'(nc == 0);
      end
      check_all($sformatf("load31 t%0d", t), (t < 65) ? 7 : 3, (t < 65) ? 3 : 1,
                nc, mc, dn, int'(t == 65 || t == 73), int'(t == 65), 1);
    end

    // Two loads in one frame (N=2 then N=5): only N=5 lands at t=81, one ack.
    for (int t = 74; t <= 92; t++) begin
      int nc, mc;
      step(1, int'(t == 74 || t == 76), (t == 74) ? 2 : 5, 1);
      if (t < 81) begin
        nc = (t - 65) % 4; mc = ((t - 65) / 4) % 2;
      end else begin
        nc = (t - 81) % 6; mc = ((t - 81) / 6) % 2;
      end
      check_all($sformatf("lastwins t%0d", t), (t < 81) ? 3 : 5, 1, nc, mc,
                int'(nc == 0), int'(t == 81), int'(t == 81), 1);
    end

    // Load during the boundary-detect cycle (N_counter=5, M_counter=1).
    for (int t = 93; t <= 97; t++) begin
      step(1, int'(t == 93), 7, 3);
      check_all($sformatf("bndload t%0d", t), 7, 3, t - 93, 0,
                int'(t == 93), int'(t == 93), int'(t == 93), 1);
    end

    // en dropped with N_counter=4.
    step(0, 0, 0, 0);
    check_all("endrop", 7, 3, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, 0);
    check_all("rerun0", 7, 3, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0);
    check_all("rerun1", 7, 3, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 2);
    check_all("pendload", 7, 3, 2, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-cycle; the pending 1/2 must be discarded.
    #2 rst_n = 1'b0;
    #1 check_all("asyncrst", 7, 3, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check_all($sformatf("postrst%0d", i), 7, 3, 0, 0, 0, 0, 0, 0);
    end
    step(1, 0, 0, 0);
    check_all("postrst_run", 7, 3, 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
